// File: rtl/sha2_msg_sched_stream_if.sv
// Stream bundle between the block loader, the SHA-2 message scheduler and the round engine.
// slave = scheduler side, master = loader/round-engine (or testbench) side.
interface sha2_msg_sched_stream_if #(
  parameter int WORD_W = 32,
  parameter int RND_W  = 7
);
  logic              block_start;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              w_valid;
  logic              w_ready;
  logic [WORD_W-1:0] w_data;
  logic [RND_W-1:0]  w_round;
  logic              w_last;
  logic              busy;
  logic              done;

  modport slave (
    input  block_start, m_valid, m_data, w_ready,
    output m_ready, w_valid, w_data, w_round, w_last, busy, done
  );

  modport master (
    output block_start, m_valid, m_data, w_ready,
    input  m_ready, w_valid, w_data, w_round, w_last, busy, done
  );
endinterface

// File: rtl/sha2_msg_sched_stream.sv
// SHA-2 message-schedule expander: 16 message words in, W[0..ROUNDS-1] out, one word per cycle.
// Optional feature: define MSG_SCHED_ABORT_EN to add the synchronous abort input.
module sha2_msg_sched_stream #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int RND_W  = 7
) (
  input logic clk,
  input logic reset_n,
`ifdef MSG_SCHED_ABORT_EN
  input logic abort,
`endif
  sha2_msg_sched_stream_if.slave sif
);
  // One extra bit so the counter can reach ROUNDS even when ROUNDS == 2**RND_W.
  localparam int CNT_W = RND_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  t_r;
  logic [WORD_W-1:0] win_r [16];
  logic [WORD_W-1:0] w_data_r;
  logic [RND_W-1:0]  w_round_r;
  logic              w_valid_r;
  logic              w_last_r;
  logic              done_r;
  logic [WORD_W-1:0] w_new_s;
  logic [WORD_W-1:0] shift_in_s;
  logic              adv_s;
  logic              abort_s;
  logic              m_ready_s;
  logic              acc_m_s;
  logic              gen_w_s;
  logic              fin_s;
  logic              drop_v_s;
  logic              shift_s;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    rotr = (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) begin
      sig0 = rotr(x, 32'd1) ^ rotr(x, 32'd8) ^ (x >> 32'd7);
    end else begin
      sig0 = rotr(x, 32'd7) ^ rotr(x, 32'd18) ^ (x >> 32'd3);
    end
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) begin
      sig1 = rotr(x, 32'd19) ^ rotr(x, 32'd61) ^ (x >> 32'd6);
    end else begin
      sig1 = rotr(x, 32'd17) ^ rotr(x, 32'd19) ^ (x >> 32'd10);
    end
  endfunction

`ifdef MSG_SCHED_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // The output register may reload whenever it is empty or being consumed this cycle.
  assign adv_s      = !w_valid_r || sif.w_ready;
  assign w_new_s    = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];
  assign shift_s    = acc_m_s || gen_w_s;
  assign shift_in_s = acc_m_s ? sif.m_data : w_new_s;

  assign sif.m_ready = m_ready_s;
  assign sif.w_valid = w_valid_r;
  assign sif.w_data  = w_data_r;
  assign sif.w_round = w_round_r;
  assign sif.w_last  = w_last_r;
  assign sif.done    = done_r;
  assign sif.busy    = (state_r != ST_IDLE);

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    m_ready_s   = 1'b0;
    acc_m_s     = 1'b0;
    gen_w_s     = 1'b0;
    fin_s       = 1'b0;
    drop_v_s    = 1'b0;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sif.block_start) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          m_ready_s = adv_s;
          if (sif.m_valid && adv_s) begin
            acc_m_s = 1'b1;
            if (t_r == CNT_W'(15)) begin
              state_nxt_s = ST_EXPAND;
            end else begin
              state_nxt_s = ST_LOAD;
            end
          end else if (adv_s) begin
            drop_v_s = 1'b1;
          end else begin
            drop_v_s = 1'b0;
          end
        end
        ST_EXPAND: begin
          if (w_valid_r && sif.w_ready && w_last_r) begin
            fin_s       = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (adv_s && (t_r < CNT_W'(ROUNDS))) begin
            gen_w_s = 1'b1;
          end else if (adv_s) begin
            drop_v_s = 1'b1;
          end else begin
            drop_v_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output register, round counter and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_r       <= {CNT_W{1'b0}};
      w_data_r  <= {WORD_W{1'b0}};
      w_round_r <= {RND_W{1'b0}};
      w_valid_r <= 1'b0;
      w_last_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= fin_s;
      if (shift_s) begin
        w_data_r  <= shift_in_s;
        w_round_r <= t_r[RND_W-1:0];
        w_valid_r <= 1'b1;
        w_last_r  <= gen_w_s && (t_r == CNT_W'(ROUNDS - 1));
        t_r       <= t_r + CNT_W'(1);
      end else if (fin_s || abort_s) begin
        w_valid_r <= 1'b0;
        w_last_r  <= 1'b0;
        t_r       <= {CNT_W{1'b0}};
      end else if (drop_v_s) begin
        w_valid_r <= 1'b0;
        w_last_r  <= 1'b0;
      end
    end
  end

  // 16-word window: win_r[0] is W[t-16], win_r[15] is W[t-1].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= {WORD_W{1'b0}};
      end
    end else if (shift_s) begin
      for (int i = 0; i < 15; i++) begin
        win_r[i] <= win_r[i+1];
      end
      win_r[15] <= shift_in_s;
    end
  end
endmodule

// File: tb/tb_sha2_msg_sched_stream.sv
// Self-checking bench for sha2_msg_sched_stream: SHA-256 and SHA-512 instances, directed vectors
// plus a reference schedule model; abort sequence included when MSG_SCHED_ABORT_EN is defined.
module tb_sha2_msg_sched_stream;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef MSG_SCHED_ABORT_EN
  logic abort = 1'b0;
`endif
  always #5 clk = ~clk;

  sha2_msg_sched_stream_if #(.WORD_W(32), .RND_W(7)) a_if ();
  sha2_msg_sched_stream_if #(.WORD_W(64), .RND_W(7)) b_if ();

  sha2_msg_sched_stream #(.WORD_W(32), .ROUNDS(64), .RND_W(7)) dut_a (
    .clk(clk), .reset_n(reset_n),
`ifdef MSG_SCHED_ABORT_EN
    .abort(abort),
`endif
    .sif(a_if)
  );

  sha2_msg_sched_stream #(.WORD_W(64), .ROUNDS(80), .RND_W(7)) dut_b (
    .clk(clk), .reset_n(reset_n),
`ifdef MSG_SCHED_ABORT_EN
    .abort(abort),
`endif
    .sif(b_if)
  );

  typedef struct {
    bit          is64;
    int          t;
    logic [63:0] w;
  } vec_t;

  vec_t        tbl [10];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] msg [16];
  logic [63:0] exp_w [128];
  logic [63:0] cap_a_d [$];
  int          cap_a_r [$];
  bit          cap_a_l [$];
  logic [63:0] cap_b_d [$];
  int          cap_b_r [$];
  bit          cap_b_l [$];
  int          done_a, done_b, mi_a, mi_b;
  bit          stall_a = 1'b0;
  logic [39:0] hold_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n, input bit is64);
    logic [127:0] d;
    if (is64) begin
      d = {x, x} >> n;
      return d[63:0];
    end else begin
      d = {64'd0, x[31:0], x[31:0]} >> n;
      return {32'd0, d[31:0]};
    end
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input bit is64);
    if (is64) return ror(x, 1, 1'b1) ^ ror(x, 8, 1'b1) ^ (x >> 7);
    else return ror(x, 7, 1'b0) ^ ror(x, 18, 1'b0) ^ ({32'd0, x[31:0]} >> 3);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input bit is64);
    if (is64) return ror(x, 19, 1'b1) ^ ror(x, 61, 1'b1) ^ (x >> 6);
    else return ror(x, 17, 1'b0) ^ ror(x, 19, 1'b0) ^ ({32'd0, x[31:0]} >> 10);
  endfunction

  task automatic model(input bit is64, input int rounds);
    logic [63:0] mask;
    mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t] & mask;
    for (int t = 16; t < rounds; t++)
      exp_w[t] = (s1(exp_w[t-2], is64) + exp_w[t-7] + s0(exp_w[t-15], is64) + exp_w[t-16]) & mask;
  endtask

  task automatic set_abc(input bit is64);
    for (int i = 0; i < 16; i++) msg[i] = 64'd0;
    msg[0]  = is64 ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
    msg[15] = 64'h18;
  endtask

  // Observe one cycle just after the falling edge, then advance to the next falling edge.
  task automatic tick();
    #1;
    if (stall_a) check("stall_hold_a", 64'({a_if.w_valid, a_if.w_last, a_if.w_round, a_if.w_data}),
                       64'({1'b1, hold_a}));
    if (a_if.m_valid && a_if.m_ready) mi_a++;
    if (b_if.m_valid && b_if.m_ready) mi_b++;
    if (a_if.w_valid && a_if.w_ready) begin
      cap_a_d.push_back({32'd0, a_if.w_data});
      cap_a_r.push_back(int'(a_if.w_round));
      cap_a_l.push_back(a_if.w_last);
    end
    if (b_if.w_valid && b_if.w_ready) begin
      cap_b_d.push_back(b_if.w_data);
      cap_b_r.push_back(int'(b_if.w_round));
      cap_b_l.push_back(b_if.w_last);
    end
    if (a_if.done) done_a++;
    if (b_if.done) done_b++;
    stall_a = a_if.w_valid && !a_if.w_ready;
    hold_a  = {a_if.w_last, a_if.w_round, a_if.w_data};
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_a"}, 64'({a_if.m_ready, a_if.w_valid, a_if.w_last, a_if.busy, a_if.done,
                              a_if.w_round, a_if.w_data}), 64'd0);
    check({name, "_b_ctl"}, 64'({b_if.m_ready, b_if.w_valid, b_if.w_last, b_if.busy, b_if.done,
                                  b_if.w_round}), 64'd0);
    check({name, "_b_data"}, b_if.w_data, 64'd0);
  endtask

  task automatic run_a(input bit rnd_rdy, input bit gaps, input bit spam, input int stop_at);
    int idx;
    cap_a_d.delete(); cap_a_r.delete(); cap_a_l.delete();
    done_a = 0;
    mi_a   = 0;
    a_if.block_start = 1'b1;
    tick();
    a_if.block_start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (stop_at >= 0 && cap_a_d.size() >= stop_at) break;
      idx = (mi_a < 16) ? mi_a : 0;
      a_if.m_valid = (mi_a < 16) && (!gaps || $urandom_range(0, 2) != 0);
      a_if.m_data  = msg[idx][31:0];
      a_if.w_ready = !rnd_rdy || ($urandom_range(0, 1) == 1);
      a_if.block_start = spam && (mi_a >= 16) && (cap_a_d.size() < 60) && ($urandom_range(0, 3) == 0);
      tick();
      if (done_a != 0) break;
    end
    a_if.m_valid     = 1'b0;
    a_if.block_start = 1'b0;
  endtask

  task automatic finish_a(input string name);
    for (int k = 0; k < 3; k++) tick();
    check({name, "_done_pulses"}, 64'(done_a), 64'd1);
    check({name, "_idle_busy"}, 64'({a_if.busy, a_if.w_valid}), 64'd0);
    check({name, "_handshakes"}, 64'(cap_a_d.size()), 64'd64);
    for (int t = 0; t < cap_a_d.size() && t < 64; t++) begin
      check($sformatf("%s_w%0d", name, t), cap_a_d[t], exp_w[t]);
      check($sformatf("%s_rnd_last%0d", name, t), 64'({cap_a_l[t], cap_a_r[t]}),
            64'({(t == 63), t}));
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 0,  64'h6162_6380};
    tbl[1] = '{1'b0, 1,  64'h0};
    tbl[2] = '{1'b0, 15, 64'h18};
    tbl[3] = '{1'b0, 16, 64'h6162_6380};
    tbl[4] = '{1'b0, 17, 64'h000F_0000};
    tbl[5] = '{1'b0, 63, 64'h12B1_EDEB};
    tbl[6] = '{1'b1, 0,  64'h6162_6380_0000_0000};
    tbl[7] = '{1'b1, 15, 64'h18};
    tbl[8] = '{1'b1, 16, 64'h6162_6380_0000_0000};
    tbl[9] = '{1'b1, 17, 64'h0003_0000_0000_00C0};

    a_if.block_start = 1'b0; a_if.m_valid = 1'b0; a_if.m_data = 32'd0; a_if.w_ready = 1'b0;
    b_if.block_start = 1'b0; b_if.m_valid = 1'b0; b_if.m_data = 64'd0; b_if.w_ready = 1'b0;
    @(negedge clk);
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // T1: SHA-256 "abc", no backpressure.
    set_abc(1'b0);
    model(1'b0, 64);
    run_a(1'b0, 1'b0, 1'b0, -1);
    finish_a("t1");
    for (int i = 0; i < 10; i++) begin
      if (!tbl[i].is64 && tbl[i].t < cap_a_d.size())
        check($sformatf("tbl256_w%0d", tbl[i].t), cap_a_d[tbl[i].t], tbl[i].w);
    end

    // T2: SHA-512 "abc", 80 rounds.
    set_abc(1'b1);
    model(1'b1, 80);
    cap_b_d.delete(); cap_b_r.delete(); cap_b_l.delete();
    done_b = 0; mi_b = 0;
    b_if.w_ready = 1'b1;
    b_if.block_start = 1'b1;
    tick();
    b_if.block_start = 1'b0;
    for (int c = 0; c < 2000 && done_b == 0; c++) begin
      b_if.m_valid = (mi_b < 16);
      b_if.m_data  = msg[(mi_b < 16) ? mi_b : 0];
      tick();
    end
    b_if.m_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("t2_done_pulses", 64'(done_b), 64'd1);
    check("t2_handshakes", 64'(cap_b_d.size()), 64'd80);
    for (int t = 0; t < cap_b_d.size() && t < 80; t++) begin
      check($sformatf("t2_w%0d", t), cap_b_d[t], exp_w[t]);
      check($sformatf("t2_rnd_last%0d", t), 64'({cap_b_l[t], cap_b_r[t]}), 64'({(t == 79), t}));
    end
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is64 && tbl[i].t < cap_b_d.size())
        check($sformatf("tbl512_w%0d", tbl[i].t), cap_b_d[tbl[i].t], tbl[i].w);
    end

    // T3: random backpressure; T4: m_valid gaps plus stray block_start during EXPAND.
    set_abc(1'b0);
    model(1'b0, 64);
    run_a(1'b1, 1'b0, 1'b0, -1);
    finish_a("t3");
    run_a(1'b1, 1'b1, 1'b1, -1);
    finish_a("t4");

    // T5: reset mid-block at t=30, then a fresh block with a different message.
    run_a(1'b0, 1'b0, 1'b0, 30);
    reset_n = 1'b0;
    stall_a = 1'b0;
    tick();
    check_reset_outputs("t5_reset");
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) msg[i] = 64'(32'h0102_0304 * (i + 1) + 32'h9E37_79B9);
    model(1'b0, 64);
    run_a(1'b1, 1'b0, 1'b0, -1);
    finish_a("t5");

`ifdef MSG_SCHED_ABORT_EN
    // T6: abort together with block_start at t=20, then a normal block.
    set_abc(1'b0);
    model(1'b0, 64);
    run_a(1'b0, 1'b0, 1'b0, 20);
    check("t6_pre_round", 64'({a_if.w_valid, a_if.w_round}), 64'({1'b1, 7'd20}));
    done_a = 0;
    abort = 1'b1;
    a_if.block_start = 1'b1;
    a_if.w_ready = 1'b1;
    tick();
    abort = 1'b0;
    a_if.block_start = 1'b0;
    a_if.w_ready = 1'b0;
    check("t6_after_abort", 64'({a_if.busy, a_if.w_valid, a_if.m_ready}), 64'd0);
    for (int k = 0; k < 3; k++) tick();
    check("t6_no_done", 64'(done_a), 64'd0);
    check("t6_stays_idle", 64'({a_if.busy, a_if.w_valid}), 64'd0);
    run_a(1'b1, 1'b0, 1'b0, -1);
    finish_a("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
